conv1x1_feeder: RTL and testbench
=================================

Name: conv1x1_feeder

Overview:
- Sequencer that drives the 16-lane 1x1 convolution datapath.
- Walks output channels, pixels and 16-channel input groups.
- Issues read addresses to the image and kernel buffers, then aligns the returned data with `data_valid`, `firstvalue` and `lastvalue` flags.
- Emits a sample strobe with pixel/output-channel indices when the datapath accumulator holds a finished result, so a downstream writer can capture it.

Parameters:
- `datwidth`, 16: element width; one buffer word holds 16 lanes (`16*datwidth` bits).
- `inputchannel`, 64: input channels; must be a multiple of 16; `GROUPS = inputchannel/16`.
- `inputsize`, 55: feature map side; `PIXELS = inputsize*inputsize`.
- `outputchannel`, 16: number of output channels (kernels) per run.
- `addrwidth`, 16: width of all buffer address ports.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `start` input 1: one-cycle pulse that begins a run; ignored unless in IDLE or DONE.
- `stall` input 1: holds issue of new reads while high.
- `img_rd_en` output 1: image buffer read enable.
- `img_addr` output addrwidth: `pixel*GROUPS + group`.
- `krn_rd_en` output 1: kernel buffer read enable; equals `img_rd_en`.
- `krn_addr` output addrwidth: `oc*GROUPS + group`.
- `bias_addr` output addrwidth: `oc`.
- `o_data_valid` output 1: buffer data valid this cycle; drives the datapath `i_data_valid`.
- `o_firstvalue` output 1: beat is group 0; drives the datapath `firstvalue`.
- `o_lastvalue` output 1: beat is group `GROUPS-1`.
- `o_sample` output 1: `o_convolved_data` is final for (`o_pix_idx`, `o_oc_idx`).
- `o_pix_idx` output addrwidth: pixel index of the sampled result.
- `o_oc_idx` output addrwidth: output-channel index of the sampled result.
- `busy` output 1: high from the cycle after accepted `start` until DONE.
- `done` output 1: one-cycle pulse on the DONE entry.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, all counters 0.
  - Reset mid-run aborts immediately; the in-flight beat is dropped (`o_data_valid` 0 next cycle).
- Memory contract: read latency exactly 1 cycle. Data for an address issued in cycle t appears in cycle t+1.
- States:
  - IDLE: wait for `start`. On `start`, clear counters and go to RUN.
  - RUN: each cycle with `stall`=0, assert `rd_en` with the current addresses and advance the counters.
    - Counter order: group innermost, then pixel, then oc.
    - After issuing the last read (`oc=outputchannel-1`, `pixel=PIXELS-1`, `group=GROUPS-1`), go to DRAIN.
  - DRAIN: stay 2 cycles to flush the data and sample pipeline, then go to DONE.
  - DONE: pulse `done` for one cycle, then return to IDLE. `start` in the DONE cycle is accepted and goes directly to RUN.
- Stall:
  - While `stall`=1, `rd_en`=0 and counters hold.
  - A beat already issued still returns with `o_data_valid`=1 next cycle.
  - Stall is permitted between groups of the same pixel: the datapath accumulator holds when valid is low.
- Beat alignment (cycle t+1 for a read issued in t):
  - `o_data_valid` = registered `rd_en`.
  - `o_firstvalue` = registered (`group==0`).
  - `o_lastvalue` = registered (`group==GROUPS-1`).
  - `firstvalue` and `lastvalue` are both high when `GROUPS`=1.
- Sample:
  - `o_sample` = registered (`o_data_valid && o_lastvalue`), i.e. cycle t+2.
  - `o_pix_idx` and `o_oc_idx` are piped alongside and are valid only while `o_sample`=1; they hold their values otherwise.
- `bias_addr`:
  - Held at the current `oc` throughout RUN; changes only when `oc` increments.
  - The bias register read must be stable by the group-0 beat.
- Widths: address arithmetic uses addrwidth-bit unsigned values. Overflow is a configuration error, caught by an elaboration-time check (`PIXELS*GROUPS` < 2^addrwidth).
- `start` while in RUN or DRAIN is ignored.

Decomposition:
- Shared package holds:
  - localparams `GROUPS` and `PIXELS`;
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - the lane count constant 16.
- One natural sub-module, `nested_counter3`: group/pixel/oc counters with enable, wrap flags and a terminal-count output.

Test Plan (small config unless noted: `inputchannel`=32 so `GROUPS`=2, `inputsize`=2 so `PIXELS`=4, `outputchannel`=2):
- Basic run: `start`, no stall.
  - `img_addr` sequence is 0,1,2,…,7 twice; `krn_addr` is 0,1 repeated 4 times, then 2,3 repeated 4 times.
  - 16 `rd_en` cycles; 8 `o_sample` pulses with (pix,oc) = (0,0)…(3,0),(0,1)…(3,1).
  - `done` pulses 19 cycles after the `start` cycle.
- Flag alignment:
  - Each `o_firstvalue` falls exactly one cycle after its `img_addr` is even.
  - Each `o_sample` falls two cycles after its odd `img_addr`.
  - `bias_addr` is 0 for the first 8 reads and 1 for the next 8.
- Stall mid-pixel: `stall` high for 3 cycles right after `img_addr`=4 is issued.
  - `o_data_valid` for address 4 still arrives.
  - No reads occur for 3 cycles; the next issued address is 5.
  - Sample count and values are unchanged vs the no-stall run; `done` arrives 3 cycles later.
- `GROUPS`=1 config (`inputchannel`=16): every beat has `o_firstvalue`=`o_lastvalue`=1, and `o_sample` follows every read by 2 cycles.
- Reset and restart:
  - `rst` asserted while `img_addr`=5: the next cycle has all outputs 0 and `busy`=0.
  - A subsequent `start` restarts from `img_addr`=0.
  - `start` pulsed during RUN has no effect.
- Back-to-back runs: `start` asserted in the `done` cycle begins a new run with no IDLE gap and a first `img_addr` of 0.

Source files
------------

// File: rtl/conv1x1_feeder_pkg.sv
`default_nettype none
// conv1x1_feeder_pkg -- lane count, sequencer state encoding and geometry helpers.
// Rev 1.0
package conv1x1_feeder_pkg;

   localparam int LANES = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Buffer words per pixel and pixel count for a given configuration.
   function automatic int f_groups(input int inputchannel);
      return inputchannel / LANES;
   endfunction

   function automatic int f_pixels(input int inputsize);
      return inputsize * inputsize;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nested_counter3.sv
`default_nettype none
// nested_counter3 -- three nested wrapping counters (c0 innermost) with terminal count.
// Rev 1.0
module nested_counter3 #(
   parameter int W  = 16,
   parameter int N0 = 4,
   parameter int N1 = 4,
   parameter int N2 = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_c0,
   output logic [W-1:0] o_c1,
   output logic [W-1:0] o_c2,
   output logic         o_wrap0,
   output logic         o_tc
);

   logic [W-1:0] r_c0;
   logic [W-1:0] r_c1;
   logic [W-1:0] r_c2;
   logic         w_wrap1;
   logic         w_wrap2;

   assign w_wrap1 = (r_c1 == W'(N1 - 1));
   assign w_wrap2 = (r_c2 == W'(N2 - 1));
   assign o_wrap0 = (r_c0 == W'(N0 - 1));
   assign o_tc    = o_wrap0 && w_wrap1 && w_wrap2;
   assign o_c0    = r_c0;
   assign o_c1    = r_c1;
   assign o_c2    = r_c2;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_c0 <= '0;
         r_c1 <= '0;
         r_c2 <= '0;
      end else if (i_en) begin
         if (o_wrap0) begin
            r_c0 <= '0;
            if (w_wrap1) begin
               r_c1 <= '0;
               r_c2 <= w_wrap2 ? '0 : r_c2 + W'(1);
            end else begin
               r_c1 <= r_c1 + W'(1);
            end
         end else begin
            r_c0 <= r_c0 + W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv1x1_feeder.sv
`default_nettype none
// conv1x1_feeder -- walks oc/pixel/group, issues buffer reads, aligns beat flags and sample strobe.
// Rev 1.0
module conv1x1_feeder
   import conv1x1_feeder_pkg::*;
#(
   parameter int datwidth      = 16,
   parameter int inputchannel  = 64,
   parameter int inputsize     = 55,
   parameter int outputchannel = 16,
   parameter int addrwidth     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stall,
   output logic                 img_rd_en,
   output logic [addrwidth-1:0] img_addr,
   output logic                 krn_rd_en,
   output logic [addrwidth-1:0] krn_addr,
   output logic [addrwidth-1:0] bias_addr,
   output logic                 o_data_valid,
   output logic                 o_firstvalue,
   output logic                 o_lastvalue,
   output logic                 o_sample,
   output logic [addrwidth-1:0] o_pix_idx,
   output logic [addrwidth-1:0] o_oc_idx,
   output logic                 busy,
   output logic                 done
);

   localparam int GROUPS = f_groups(inputchannel);
   localparam int PIXELS = f_pixels(inputsize);

   generate
      if (datwidth < 1 || (inputchannel % LANES) != 0 || GROUPS < 1 || outputchannel < 1 ||
          longint'(PIXELS) * GROUPS >= (64'd1 << addrwidth) ||
          longint'(outputchannel) * GROUPS >= (64'd1 << addrwidth)) begin : g_cfg_err
         $error("conv1x1_feeder: illegal configuration or address overflow");
      end
   endgenerate

   state_t               r_state;
   state_t               w_next;
   logic                 r_drain;
   logic                 w_issue;
   logic                 w_clr;
   logic                 w_busy;
   logic                 w_done;
   logic [addrwidth-1:0] w_grp;
   logic [addrwidth-1:0] w_pix;
   logic [addrwidth-1:0] w_oc;
   logic                 w_grp_last;
   logic                 w_tc;

   logic                 r_dv;
   logic                 r_first;
   logic                 r_last;
   logic                 r_sample;
   logic [addrwidth-1:0] r_pix_d;
   logic [addrwidth-1:0] r_oc_d;
   logic [addrwidth-1:0] r_pix_idx;
   logic [addrwidth-1:0] r_oc_idx;

   nested_counter3 #(
      .W  (addrwidth),
      .N0 (GROUPS),
      .N1 (PIXELS),
      .N2 (outputchannel)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_en    (w_issue),
      .o_c0    (w_grp),
      .o_c1    (w_pix),
      .o_c2    (w_oc),
      .o_wrap0 (w_grp_last),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_drain <= 1'b0;
      end else begin
         r_state <= w_next;
         r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_clr   = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_clr = start;
            if (start) w_next = ST_RUN;
         end
         ST_RUN: begin
            w_busy  = 1'b1;
            w_issue = !stall;
            if (!stall && w_tc) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (r_drain) w_next = ST_DONE;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_clr  = start;
            w_next = start ? ST_RUN : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // One-cycle buffer latency: flags ride with the beat, sample strobe one stage later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dv      <= 1'b0;
         r_first   <= 1'b0;
         r_last    <= 1'b0;
         r_sample  <= 1'b0;
         r_pix_d   <= '0;
         r_oc_d    <= '0;
         r_pix_idx <= '0;
         r_oc_idx  <= '0;
      end else begin
         r_dv     <= w_issue;
         r_first  <= w_issue && (w_grp == '0);
         r_last   <= w_issue && w_grp_last;
         r_sample <= r_dv && r_last;
         if (w_issue) begin
            r_pix_d <= w_pix;
            r_oc_d  <= w_oc;
         end
         if (r_dv && r_last) begin
            r_pix_idx <= r_pix_d;
            r_oc_idx  <= r_oc_d;
         end
      end
   end

   assign img_rd_en    = w_issue;
   assign krn_rd_en    = w_issue;
   assign img_addr     = w_pix * addrwidth'(GROUPS) + w_grp;
   assign krn_addr     = w_oc * addrwidth'(GROUPS) + w_grp;
   assign bias_addr    = w_oc;
   assign o_data_valid = r_dv;
   assign o_firstvalue = r_first;
   assign o_lastvalue  = r_last;
   assign o_sample     = r_sample;
   assign o_pix_idx    = r_pix_idx;
   assign o_oc_idx     = r_oc_idx;
   assign busy         = w_busy;
   assign done         = w_done;

endmodule
`default_nettype wire

// File: tb/tb_conv1x1_feeder.sv
`default_nettype none
// tb_conv1x1_feeder -- scoreboard bench: GROUPS=2 instance (a_) and GROUPS=1 instance (b_).
// Rev 1.0
`timescale 1ns/1ps
module tb_conv1x1_feeder;

   localparam int AW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic a_start = 1'b0, a_stall = 1'b0, b_start = 1'b0, b_stall = 1'b0;
   logic a_img_rd_en, a_krn_rd_en, a_dv, a_first, a_last, a_sample, a_busy, a_done;
   logic b_img_rd_en, b_krn_rd_en, b_dv, b_first, b_last, b_sample, b_busy, b_done;
   logic [AW-1:0] a_img_addr, a_krn_addr, a_bias_addr, a_pix, a_oc;
   logic [AW-1:0] b_img_addr, b_krn_addr, b_bias_addr, b_pix, b_oc;

   conv1x1_feeder #(.datwidth(16), .inputchannel(32), .inputsize(2), .outputchannel(2), .addrwidth(AW)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .stall(a_stall),
      .img_rd_en(a_img_rd_en), .img_addr(a_img_addr), .krn_rd_en(a_krn_rd_en), .krn_addr(a_krn_addr),
      .bias_addr(a_bias_addr), .o_data_valid(a_dv), .o_firstvalue(a_first), .o_lastvalue(a_last),
      .o_sample(a_sample), .o_pix_idx(a_pix), .o_oc_idx(a_oc), .busy(a_busy), .done(a_done));

   conv1x1_feeder #(.datwidth(16), .inputchannel(16), .inputsize(2), .outputchannel(2), .addrwidth(AW)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .stall(b_stall),
      .img_rd_en(b_img_rd_en), .img_addr(b_img_addr), .krn_rd_en(b_krn_rd_en), .krn_addr(b_krn_addr),
      .bias_addr(b_bias_addr), .o_data_valid(b_dv), .o_firstvalue(b_first), .o_lastvalue(b_last),
      .o_sample(b_sample), .o_pix_idx(b_pix), .o_oc_idx(b_oc), .busy(b_busy), .done(b_done));

   typedef struct packed { logic [15:0] img; logic [15:0] krn; logic [15:0] bias; } rd_t;
   typedef struct packed { logic [15:0] pix; logic [15:0] oc; } smp_t;

   rd_t  qa_rd[$], qb_rd[$];
   smp_t qa_s[$],  qb_s[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected reads in issue order and expected samples, GROUPS=2 / PIXELS=4 / OC=2.
   task automatic push_full_a();
      for (int oc = 0; oc < 2; oc++) begin
         for (int p = 0; p < 4; p++) begin
            for (int g = 0; g < 2; g++) qa_rd.push_back('{16'(p*2+g), 16'(oc*2+g), 16'(oc)});
            qa_s.push_back('{16'(p), 16'(oc)});
         end
      end
   endtask

   task automatic push_full_b();
      for (int oc = 0; oc < 2; oc++) begin
         for (int p = 0; p < 4; p++) begin
            qb_rd.push_back('{16'(p), 16'(oc), 16'(oc)});
            qb_s.push_back('{16'(p), 16'(oc)});
         end
      end
   endtask

   // Monitor A: beat flags follow the previous cycle's read; sample follows the last beat.
   bit            a_prd = 1'b0, a_prst = 1'b1, a_pdvl = 1'b0;
   logic [AW-1:0] a_paddr = '0;
   always begin
      bit e_dv, e_last;
      rd_t r; smp_t s;
      @(negedge clk); #1;
      e_dv   = a_prd && !a_prst;
      e_last = e_dv && a_paddr[0];
      if (mon_on) begin
         chk("a_data_valid", 32'(a_dv), 32'(e_dv));
         chk("a_firstvalue", 32'(a_first), 32'(e_dv && !a_paddr[0]));
         chk("a_lastvalue", 32'(a_last), 32'(e_last));
         chk("a_sample", 32'(a_sample), 32'(a_pdvl && !a_prst));
         chk("a_krn_rd_en", 32'(a_krn_rd_en), 32'(a_img_rd_en));
         if (a_img_rd_en === 1'b1) begin
            if (qa_rd.size() == 0) chk("a_unexpected_read", 32'(a_img_addr), 32'hFFFF);
            else begin
               r = qa_rd.pop_front();
               chk("a_img_addr", 32'(a_img_addr), 32'(r.img));
               chk("a_krn_addr", 32'(a_krn_addr), 32'(r.krn));
               chk("a_bias_addr", 32'(a_bias_addr), 32'(r.bias));
            end
         end
         if (a_sample === 1'b1) begin
            if (qa_s.size() == 0) chk("a_unexpected_sample", 32'(a_pix), 32'hFFFF);
            else begin
               s = qa_s.pop_front();
               chk("a_pix_idx", 32'(a_pix), 32'(s.pix));
               chk("a_oc_idx", 32'(a_oc), 32'(s.oc));
            end
         end
      end
      a_pdvl  = e_last;
      a_prd   = (a_img_rd_en === 1'b1);
      a_paddr = a_img_addr;
      a_prst  = (rst !== 1'b0);
   end

   // Monitor B: with one group every beat is both first and last.
   bit b_prd = 1'b0, b_prst = 1'b1, b_pdv = 1'b0;
   always begin
      bit e_dv;
      rd_t r; smp_t s;
      @(negedge clk); #1;
      e_dv = b_prd && !b_prst;
      if (mon_on) begin
         chk("b_data_valid", 32'(b_dv), 32'(e_dv));
         chk("b_firstvalue", 32'(b_first), 32'(e_dv));
         chk("b_lastvalue", 32'(b_last), 32'(e_dv));
         chk("b_sample", 32'(b_sample), 32'(b_pdv && !b_prst));
         if (b_img_rd_en === 1'b1) begin
            if (qb_rd.size() == 0) chk("b_unexpected_read", 32'(b_img_addr), 32'hFFFF);
            else begin
               r = qb_rd.pop_front();
               chk("b_img_addr", 32'(b_img_addr), 32'(r.img));
               chk("b_krn_addr", 32'(b_krn_addr), 32'(r.krn));
               chk("b_bias_addr", 32'(b_bias_addr), 32'(r.bias));
            end
         end
         if (b_sample === 1'b1) begin
            if (qb_s.size() == 0) chk("b_unexpected_sample", 32'(b_pix), 32'hFFFF);
            else begin
               s = qb_s.pop_front();
               chk("b_pix_idx", 32'(b_pix), 32'(s.pix));
               chk("b_oc_idx", 32'(b_oc), 32'(s.oc));
            end
         end
      end
      b_pdv = e_dv;
      b_prd = (b_img_rd_en === 1'b1);
      b_prst = (rst !== 1'b0);
   end

   task automatic kick_a();
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
   endtask

   // Called at the falling edge of run cycle 1; cycle numbers count from the start cycle (0).
   task automatic wait_a(input int stall_at, input int stall_len, input int rst_at,
                         input int start_at, input int exp_done, input bit chain);
      int cnt = 1;
      bit seen = 1'b0;
      while (cnt < 60) begin
         if (stall_len > 0 && cnt == stall_at) a_stall = 1'b1;
         if (stall_len > 0 && cnt == stall_at + stall_len) a_stall = 1'b0;
         if (start_at > 0) a_start = (cnt == start_at);
         if (cnt == 1) chk("a_busy_run", 32'(a_busy), 32'd1);
         if (rst_at > 0 && cnt == rst_at) begin
            chk("a_addr_at_rst", 32'(a_img_addr), 32'd5);
            rst = 1'b1;
         end
         if (rst_at > 0 && cnt == rst_at + 1) begin
            rst = 1'b0;
            chk("rst_img_rd_en", 32'(a_img_rd_en), 32'd0);
            chk("rst_krn_rd_en", 32'(a_krn_rd_en), 32'd0);
            chk("rst_img_addr", 32'(a_img_addr), 32'd0);
            chk("rst_krn_addr", 32'(a_krn_addr), 32'd0);
            chk("rst_bias_addr", 32'(a_bias_addr), 32'd0);
            chk("rst_flags", 32'({a_dv, a_first, a_last, a_sample}), 32'd0);
            chk("rst_idx", 32'({a_pix, a_oc}), 32'd0);
            chk("rst_busy_done", 32'({a_busy, a_done}), 32'd0);
            return;
         end
         if (a_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         cnt++;
      end
      a_start = 1'b0;
      chk("a_done_cycle", seen ? 32'(cnt) : 32'd0, 32'(exp_done));
      if (chain) begin
         a_start = 1'b1;
         @(negedge clk);
         a_start = 1'b0;
         chk("b2b_first_rd", 32'(a_img_rd_en), 32'd1);
         chk("b2b_first_addr", 32'(a_img_addr), 32'd0);
      end else begin
         @(negedge clk);
         chk("a_done_pulse", 32'(a_done), 32'd0);
         chk("a_busy_after", 32'(a_busy), 32'd0);
      end
   endtask

   initial begin
      int cnt;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mon_on = 1'b1;
      chk("reset_rd_en", 32'({a_img_rd_en, a_krn_rd_en, b_img_rd_en}), 32'd0);
      chk("reset_addr", 32'(a_img_addr), 32'd0);
      chk("reset_flags", 32'({a_dv, a_first, a_last, a_sample, a_busy, a_done}), 32'd0);

      push_full_a(); kick_a(); wait_a(0, 0, 0, 0, 19, 1'b0);   // basic run
      push_full_a(); kick_a(); wait_a(6, 3, 0, 0, 22, 1'b0);   // stall after addr 4
      push_full_a(); kick_a(); wait_a(0, 0, 0, 5, 19, 1'b0);   // start during RUN ignored

      for (int i = 0; i < 6; i++) qa_rd.push_back('{16'(i), 16'(i % 2), 16'd0});
      qa_s.push_back('{16'd0, 16'd0});
      qa_s.push_back('{16'd1, 16'd0});
      kick_a(); wait_a(0, 0, 6, 0, 0, 1'b0);                   // reset while addr 5 issued

      push_full_a(); push_full_a();
      kick_a(); wait_a(0, 0, 0, 0, 19, 1'b1);                  // restart, then back-to-back
      wait_a(0, 0, 0, 0, 19, 1'b0);

      push_full_b();
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      cnt = 1;
      while (b_done !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("b_done_cycle", 32'(cnt), 32'd11);

      repeat (4) @(negedge clk);
      chk("qa_rd_empty", 32'(qa_rd.size()), 32'd0);
      chk("qa_s_empty", 32'(qa_s.size()), 32'd0);
      chk("qb_rd_empty", 32'(qb_rd.size()), 32'd0);
      chk("qb_s_empty", 32'(qb_s.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
